// File: rtl/car_lane.sv
// car_lane: one road row of the Frogger LED matrix.
//
// Shows one lit column every PERIOD columns and rotates that pattern by one column per step.
// Steps come from an internal tick counter whose terminal count is chosen at run time by
// speed. The lane can be paused, and a hit freezes it blank (game over) until reset.
//
// Ports:
//   clk    - system clock, all state changes on posedge
//   reset  - synchronous, active-high reset
//   hit    - collision with the frog, level-sampled every clock
//   pause  - 1 holds the tick counter and phase
//   speed  - step rate select, 0 slowest .. 3 fastest
//   pixels - lit-column vector, bit WIDTH-1 is the leftmost column
//   phase  - current pattern phase
//   dead   - 1 while the lane is in the game-over state
module car_lane #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned PERIOD      = 4,
  parameter int unsigned TICK_WIDTH  = 10,
  parameter bit          DIR         = 1'b0,
  parameter int unsigned RESET_PHASE = 2,
  localparam int unsigned PW         = (PERIOD > 2) ? $clog2(PERIOD) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hit,
  input  logic             pause,
  input  logic [1:0]       speed,
  output logic [WIDTH-1:0] pixels,
  output logic [PW-1:0]    phase,
  output logic             dead
);

  typedef enum logic [0:0] {StRun, StGg} state_e;

  state_e                state_q;
  logic [TICK_WIDTH-1:0] tick_q;
  logic [PW-1:0]         phase_q;
  logic [TICK_WIDTH-1:0] term;
  logic [PW-1:0]         phase_next;

  // (2^TW >> speed) - 1 equals the all-ones value shifted right by speed, since TW >= 4.
  assign term = {TICK_WIDTH{1'b1}} >> speed;

  // Phase stays within 0..PERIOD-1 by explicit wrap in both directions.
  always_comb begin
    phase_next = phase_q;
    if (DIR) begin
      phase_next = (phase_q == PW'(PERIOD - 1)) ? '0 : phase_q + 1'b1;
    end else begin
      phase_next = (phase_q == '0) ? PW'(PERIOD - 1) : phase_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      tick_q  <= '0;
      phase_q <= PW'(RESET_PHASE);
    end else begin
      unique case (state_q)
        StRun: begin
          // Hit wins over a coincident step: phase is left untouched on that edge.
          if (hit) begin
            state_q <= StGg;
          end else if (!pause) begin
            // Compare with >= so a speed change to a smaller count steps immediately.
            if (tick_q >= term) begin
              tick_q  <= '0;
              phase_q <= phase_next;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end
        StGg: begin
          state_q <= StGg;
        end
        default: begin
          state_q <= StRun;
        end
      endcase
    end
  end

  always_comb begin
    pixels = '0;
    if (state_q == StRun) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        pixels[i] = ((int'(WIDTH) - 1 - i) % int'(PERIOD)) == int'(phase_q);
      end
    end
  end

  assign phase = phase_q;
  assign dead  = (state_q == StGg);

endmodule

// File: tb/tb_car_lane.sv
module tb_car_lane;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, hit, pause;
  logic [1:0]  speed;
  logic [15:0] pixels;
  logic [1:0]  phase;
  logic        dead;

  logic        reset2, hit2, pause2;
  logic [1:0]  speed2;
  logic [7:0]  pixels2;
  logic [1:0]  phase2;
  logic        dead2;

  car_lane #(
    .WIDTH(16), .PERIOD(4), .TICK_WIDTH(4), .DIR(1'b0), .RESET_PHASE(2)
  ) dut (
    .clk(clk), .reset(reset), .hit(hit), .pause(pause), .speed(speed),
    .pixels(pixels), .phase(phase), .dead(dead)
  );

  car_lane #(
    .WIDTH(8), .PERIOD(3), .TICK_WIDTH(4), .DIR(1'b1), .RESET_PHASE(0)
  ) dut2 (
    .clk(clk), .reset(reset2), .hit(hit2), .pause(pause2), .speed(speed2),
    .pixels(pixels2), .phase(phase2), .dead(dead2)
  );

  typedef struct packed {
    logic [15:0] pix;
    logic [1:0]  ph;
    logic        dead;
  } obs_t;

  obs_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  bit m_run;
  int m_tick;
  int m_phase;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] pat(input int ph);
    logic [15:0] p;
    for (int i = 0; i < 16; i++) p[i] = ((15 - i) % 4) == ph;
    return p;
  endfunction

  task automatic model_edge(input bit r, input bit h, input bit p, input int s);
    int t;
    if (r) begin
      m_run = 1; m_tick = 0; m_phase = 2;
    end else if (m_run) begin
      if (h) begin
        m_run = 0;
      end else if (!p) begin
        t = (16 >> s) - 1;
        if (m_tick >= t) begin
          m_tick  = 0;
          m_phase = (m_phase == 0) ? 3 : m_phase - 1;
        end else begin
          m_tick++;
        end
      end
    end
  endtask

  // Drive one cycle, push the model's expectation, then compare against the DUT after the edge.
  task automatic cyc(input bit r, input bit h, input bit p, input int s);
    obs_t e;
    reset = r; hit = h; pause = p; speed = 2'(s);
    model_edge(r, h, p, s);
    e.pix  = m_run ? pat(m_phase) : 16'h0000;
    e.ph   = 2'(m_phase);
    e.dead = !m_run;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("pixels", 64'(pixels), 64'(e.pix));
    check("phase", 64'(phase), 64'(e.ph));
    check("dead", 64'(dead), 64'(e.dead));
  endtask

  task automatic run(input int n, input bit p, input int s);
    for (int k = 0; k < n; k++) cyc(0, 0, p, s);
  endtask

  initial begin
    reset = 1; hit = 0; pause = 0; speed = 0;
    reset2 = 1; hit2 = 0; pause2 = 0; speed2 = 2'd3;
    m_run = 1; m_tick = 0; m_phase = 2;
    @(negedge clk);

    // Reset state and slow rotation
    cyc(1, 0, 0, 0);
    check("rst_pix", 64'(pixels), 64'h2222);
    check("rst_dead", 64'(dead), 64'h0);
    run(15, 0, 0);
    check("hold15_ph", 64'(phase), 64'h2);
    run(1, 0, 0);
    check("step1_pix", 64'(pixels), 64'h4444);
    run(16, 0, 0);
    check("step2_pix", 64'(pixels), 64'h8888);
    run(16, 0, 0);
    check("step3_pix", 64'(pixels), 64'h1111);
    run(16, 0, 0);
    check("wrap_ph", 64'(phase), 64'h2);

    // Speed 0 -> 3 with tick=9: step on the very next edge
    run(9, 0, 0);
    check("pre_sw_ph", 64'(phase), 64'h2);
    cyc(0, 0, 0, 3);
    check("sw_step_ph", 64'(phase), 64'h1);
    run(1, 0, 3);
    check("fast_hold", 64'(phase), 64'h1);
    run(1, 0, 3);
    check("fast_step", 64'(phase), 64'h0);
    run(6, 0, 3);

    // Pause mid-interval keeps the remaining count
    cyc(1, 0, 0, 0);
    run(5, 0, 0);
    run(40, 1, 0);
    check("pause_ph", 64'(phase), 64'h2);
    run(10, 0, 0);
    check("pause_pre", 64'(phase), 64'h2);
    run(1, 0, 0);
    check("pause_step", 64'(pixels), 64'h4444);

    // Reset during pause clears the tick count
    run(7, 0, 0);
    run(3, 1, 0);
    cyc(1, 0, 1, 0);
    run(15, 0, 0);
    check("rstp_hold", 64'(phase), 64'h2);
    run(1, 0, 0);
    check("rstp_step", 64'(phase), 64'h1);

    // Hit exactly at tick==T: game over, no step
    cyc(1, 0, 0, 0);
    run(15, 0, 0);
    cyc(0, 1, 0, 0);
    check("gg_dead", 64'(dead), 64'h1);
    check("gg_pix", 64'(pixels), 64'h0);
    check("gg_ph", 64'(phase), 64'h2);
    for (int k = 0; k < 100; k++) begin
      cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end
    check("gg_stay", 64'({dead, pixels}), 64'h1_0000);
    cyc(1, 1, 1, 2);
    check("gg_rst_pix", 64'(pixels), 64'h2222);
    check("gg_rst_dead", 64'(dead), 64'h0);

    // DIR=1, PERIOD=3, WIDTH=8 instance at T=1
    @(negedge clk);
    reset2 = 1;
    @(posedge clk); #1;
    reset2 = 0;
    check("d1_ph0", 64'(phase2), 64'h0);
    check("d1_pix0", 64'(pixels2), 64'h92);
    check("d1_dead", 64'(dead2), 64'h0);
    @(posedge clk); #1;
    check("d1_hold", 64'(phase2), 64'h0);
    @(posedge clk); #1;
    check("d1_ph1", 64'(phase2), 64'h1);
    check("d1_pix1", 64'(pixels2), 64'h49);
    repeat (2) @(posedge clk);
    #1;
    check("d1_ph2", 64'(phase2), 64'h2);
    check("d1_pix2", 64'(pixels2), 64'h24);
    repeat (2) @(posedge clk);
    #1;
    check("d1_wrap", 64'(phase2), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule
